led_rgb_sequencer: RTL and testbench

Table-driven pattern player that sits directly upstream of the `led_rgb` core and drives its per-channel configuration inputs (`mode_*`, `enable_*`, `holded_*`, `duration_*`). Software loads a small step table, then starts playback. The sequencer applies each step's configuration for a programmed dwell time, either once or looping, so colour/blink sequences run without CPU involvement. It also emits a per-step pulse that the wrapper uses to restart the core's blink counters.

---
 rtl/led_rgb_pkg.sv | 22 ++
 rtl/led_rgb_seq_ram.sv | 43 ++++
 rtl/led_rgb_sequencer.sv | 158 +++++++++++++++
 tb/tb_led_rgb_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_rgb_pkg.sv
// Shared constants and types for the LED RGB step sequencer.
package led_rgb_pkg;

  // Flags word layout: each field is {b,g,r} with r in the lowest bit
  localparam int FLG_EN_LSB   = 0;
  localparam int FLG_MODE_LSB = 3;
  localparam int FLG_HOLD_LSB = 6;
  localparam int FLAGS_W      = 9;

  // Word index within one step entry (low two bits of the write address)
  localparam logic [1:0] WORD_FLAGS = 2'd0;
  localparam logic [1:0] WORD_DUR   = 2'd1;
  localparam logic [1:0] WORD_DWELL = 2'd2;

  // Playback FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/led_rgb_seq_ram.sv
// Step table: simple dual-port RAM, one write and one synchronous read per
// cycle. Each step is stored as three word lanes (flags, duration, dwell)
// selected by the word index of the write address. A read colliding with a
// write to the same entry returns the old contents.
module led_rgb_seq_ram
  import led_rgb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SW    = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_wr_en,
  input  logic [SW-1:0]      i_wr_step,
  input  logic [1:0]         i_wr_word,
  input  logic [31:0]        i_wr_data,
  input  logic [SW-1:0]      i_rd_step,
  output logic [FLAGS_W-1:0] o_rd_flags,
  output logic [31:0]        o_rd_dur,
  output logic [31:0]        o_rd_dwell
);

  logic [FLAGS_W-1:0] r_flags_mem [DEPTH];
  logic [31:0]        r_dur_mem   [DEPTH];
  logic [31:0]        r_dwell_mem [DEPTH];
  logic [FLAGS_W-1:0] r_rd_flags;
  logic [31:0]        r_rd_dur;
  logic [31:0]        r_rd_dwell;

  // Lane writes plus registered read; nonblocking order gives read-old.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && (i_wr_word == WORD_FLAGS)) r_flags_mem[i_wr_step] <= i_wr_data[FLAGS_W-1:0];
    if (i_wr_en && (i_wr_word == WORD_DUR))   r_dur_mem[i_wr_step]   <= i_wr_data;
    if (i_wr_en && (i_wr_word == WORD_DWELL)) r_dwell_mem[i_wr_step] <= i_wr_data;
    r_rd_flags <= r_flags_mem[i_rd_step];
    r_rd_dur   <= r_dur_mem[i_rd_step];
    r_rd_dwell <= r_dwell_mem[i_rd_step];
  end

  assign o_rd_flags = r_rd_flags;
  assign o_rd_dur   = r_rd_dur;
  assign o_rd_dwell = r_rd_dwell;

endmodule

// File: rtl/led_rgb_sequencer.sv
// Table-driven pattern player feeding the led_rgb core configuration inputs.
// The RAM is read every cycle at the entry that follows the step that will be
// current in the next cycle, so the read data always holds the upcoming step
// and consecutive steps abut without gap cycles, even for one-cycle dwells.
module led_rgb_sequencer
  import led_rgb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [SW+1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic [SW-1:0] last_step,
  output logic          mode_r,
  output logic          mode_g,
  output logic          mode_b,
  output logic          enable_r,
  output logic          enable_g,
  output logic          enable_b,
  output logic          holded_r,
  output logic          holded_g,
  output logic          holded_b,
  output logic [31:0]   duration_r,
  output logic [31:0]   duration_g,
  output logic [31:0]   duration_b,
  output logic          step_pulse,
  output logic [SW-1:0] cur_step,
  output logic          busy,
  output logic          done
);

  seq_state_t         r_state;
  logic               r_start;
  logic [SW-1:0]      r_step;
  logic [31:0]        r_cnt;
  logic [2:0]         r_en;
  logic [2:0]         r_mode;
  logic [2:0]         r_hold;
  logic [31:0]        r_dur;
  logic               r_busy;
  logic               r_done;
  logic               r_pulse;

  logic [FLAGS_W-1:0] w_rd_flags;
  logic [31:0]        w_rd_dur;
  logic [31:0]        w_rd_dwell;
  logic [SW-1:0]      w_rd_step;
  logic [SW-1:0]      w_next;
  logic [SW-1:0]      w_apply_step;
  logic               w_bnd;
  logic               w_apply;
  logic               w_finish;

  // Index that follows s in playback order (wraps to 0 after last)
  function automatic logic [SW-1:0] succ(input logic [SW-1:0] s, input logic [SW-1:0] last);
    return (s == last) ? {SW{1'b0}} : s + 1'b1;
  endfunction

  led_rgb_seq_ram #(.DEPTH(DEPTH), .SW(SW)) u_ram (
    .i_clk      (clk),
    .i_wr_en    (wr_en),
    .i_wr_step  (wr_addr[SW+1:2]),
    .i_wr_word  (wr_addr[1:0]),
    .i_wr_data  (wr_data),
    .i_rd_step  (w_rd_step),
    .o_rd_flags (w_rd_flags),
    .o_rd_dur   (w_rd_dur),
    .o_rd_dwell (w_rd_dwell)
  );

  // Boundary decode and read address selection
  always_comb begin
    w_bnd        = (r_state == ST_RUN) && (r_cnt == 32'd1);
    w_next       = succ(r_step, last_step);
    w_apply      = 1'b0;
    w_finish     = 1'b0;
    w_apply_step = w_next;
    if (r_state == ST_LOAD) begin
      w_apply      = 1'b1;
      w_apply_step = {SW{1'b0}};
    end else if (w_bnd) begin
      if ((r_step != last_step) || loop) w_apply  = 1'b1;
      else                               w_finish = 1'b1;
    end
    case (r_state)
      ST_LOAD: w_rd_step = succ({SW{1'b0}}, last_step);
      ST_RUN:  w_rd_step = w_bnd ? succ(w_next, last_step) : w_next;
      default: w_rd_step = {SW{1'b0}};
    endcase
  end

  // Playback FSM with registered core-facing outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_start <= 1'b0;
      r_step  <= '0;
      r_cnt   <= '0;
      r_en    <= '0;
      r_mode  <= '0;
      r_hold  <= '0;
      r_dur   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_start <= start && !stop && (r_state == ST_IDLE);
      r_pulse <= 1'b0;
      r_done  <= 1'b0;
      if (stop || w_finish) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_en    <= '0;
        r_mode  <= '0;
        r_hold  <= '0;
        r_done  <= w_finish && !stop;
      end else if (w_apply) begin
        r_state <= ST_RUN;
        r_step  <= w_apply_step;
        r_en    <= w_rd_flags[FLG_EN_LSB +: 3];
        r_mode  <= w_rd_flags[FLG_MODE_LSB +: 3];
        r_hold  <= w_rd_flags[FLG_HOLD_LSB +: 3];
        r_dur   <= w_rd_dur;
        r_cnt   <= (w_rd_dwell == 32'd0) ? 32'd1 : w_rd_dwell;
        r_pulse <= 1'b1;
      end else if ((r_state == ST_IDLE) && r_start) begin
        r_state <= ST_LOAD;
        r_busy  <= 1'b1;
      end else if (r_state == ST_RUN) begin
        r_cnt <= r_cnt - 32'd1;
      end
    end
  end

  assign enable_r   = r_en[0];
  assign enable_g   = r_en[1];
  assign enable_b   = r_en[2];
  assign mode_r     = r_mode[0];
  assign mode_g     = r_mode[1];
  assign mode_b     = r_mode[2];
  assign holded_r   = r_hold[0];
  assign holded_g   = r_hold[1];
  assign holded_b   = r_hold[2];
  assign duration_r = r_dur;
  assign duration_g = r_dur;
  assign duration_b = r_dur;
  assign step_pulse = r_pulse;
  assign cur_step   = r_step;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_led_rgb_sequencer.sv
// Bench for led_rgb_sequencer: table-driven playback plus multi-cycle corner
// sequences (loop, stop, start+stop, live table rewrite, reset mid-run).
module tb_led_rgb_sequencer;

  localparam int DEPTH = 16;
  localparam int SW    = 4;
  localparam int W     = 9 + 96 + SW + 3;

  logic          clk = 1'b0;
  logic          reset, wr_en, start, stop, loop;
  logic [SW+1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [SW-1:0] last_step;
  logic          mode_r, mode_g, mode_b, enable_r, enable_g, enable_b;
  logic          holded_r, holded_g, holded_b, step_pulse, busy, done;
  logic [31:0]   duration_r, duration_g, duration_b;
  logic [SW-1:0] cur_step;

  // Clock
  always #5 clk = ~clk;

  led_rgb_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop(loop), .last_step(last_step),
    .mode_r(mode_r), .mode_g(mode_g), .mode_b(mode_b),
    .enable_r(enable_r), .enable_g(enable_g), .enable_b(enable_b),
    .holded_r(holded_r), .holded_g(holded_g), .holded_b(holded_b),
    .duration_r(duration_r), .duration_g(duration_g), .duration_b(duration_b),
    .step_pulse(step_pulse), .cur_step(cur_step), .busy(busy), .done(done)
  );

  typedef struct {
    logic [8:0]  flags;
    logic [31:0] dur;
    logic [31:0] dwell;
    int          hold;
  } vec_t;

  vec_t        vecs[3];
  logic [8:0]  m_flags [DEPTH];
  logic [31:0] m_dur_tbl [DEPTH];
  logic [31:0] m_dur;
  logic [SW-1:0] m_step;
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  logic [W-1:0] act;
  assign act = {enable_b, enable_g, enable_r, mode_b, mode_g, mode_r,
                holded_b, holded_g, holded_r, duration_r, duration_g, duration_b,
                cur_step, busy, done, step_pulse};

  function automatic logic [W-1:0] mk(logic [8:0] f, logic [31:0] d, logic [SW-1:0] s,
                                      logic b, logic dn, logic p);
    return {f[2:0], f[5:3], f[8:6], d, d, d, s, b, dn, p};
  endfunction

  task automatic push_step(int s, logic p);
    m_dur  = m_dur_tbl[s];
    m_step = SW'(s);
    exp_q.push_back(mk(m_flags[s], m_dur, m_step, 1'b1, 1'b0, p));
  endtask

  task automatic push_idle(logic b, logic dn);
    exp_q.push_back(mk(9'b0, m_dur, m_step, b, dn, 1'b0));
  endtask

  // Advance one clock and compare the oldest expectation at the falling edge
  task automatic run_cycle(string name);
    logic [W-1:0] e;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: got %h with no expected entry queued", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got %h expected %h", name, act, e);
      end
    end
  endtask

  task automatic write_word(int s, int w, logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = {SW'(s), 2'(w)};
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    push_idle(1'b0, 1'b0);
    run_cycle("start_edge");
    start = 1'b0;
    push_idle(1'b1, 1'b0);
    run_cycle("load");
  endtask

  task automatic play_once();
    do_start();
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < vecs[i].hold; c++) begin
        push_step(i, c == 0);
        run_cycle($sformatf("play_s%0d_c%0d", i, c));
      end
    push_idle(1'b0, 1'b1);
    run_cycle("done_pulse");
    push_idle(1'b0, 1'b0);
    run_cycle("after_done");
  endtask

  // Whole-run time limit
  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Main sequence
  initial begin
    vecs[0] = '{flags: 9'b001_010_101, dur: 32'h1111_0003, dwell: 32'd3, hold: 3};
    vecs[1] = '{flags: 9'b100_110_011, dur: 32'h2222_0001, dwell: 32'd1, hold: 1};
    vecs[2] = '{flags: 9'b010_001_111, dur: 32'h3333_0000, dwell: 32'd0, hold: 1};

    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0; last_step = SW'(2);
    m_dur = '0; m_step = '0;

    push_idle(1'b0, 1'b0);
    run_cycle("reset_state");
    reset = 1'b0;
    push_idle(1'b0, 1'b0);
    run_cycle("idle_after_reset");

    for (int i = 0; i < 3; i++) begin
      write_word(i, 0, 32'hFFFF_FE00 | 32'(vecs[i].flags));
      write_word(i, 1, vecs[i].dur);
      write_word(i, 2, vecs[i].dwell);
      m_flags[i]   = vecs[i].flags;
      m_dur_tbl[i] = vecs[i].dur;
    end

    // One-shot playback
    play_once();

    // Looping playback, stopped in step 0 of the third pass
    loop = 1'b1;
    do_start();
    for (int pass = 0; pass < 2; pass++)
      for (int i = 0; i < 3; i++)
        for (int c = 0; c < vecs[i].hold; c++) begin
          push_step(i, c == 0);
          run_cycle($sformatf("loop_p%0d_s%0d_c%0d", pass, i, c));
        end
    push_step(0, 1'b1);
    run_cycle("loop_wrap_s0");
    stop = 1'b1;
    push_idle(1'b0, 1'b0);
    run_cycle("loop_stop");
    stop = 1'b0;
    loop = 1'b0;

    // Stop during step 1, then restart
    do_start();
    for (int c = 0; c < 3; c++) begin
      push_step(0, c == 0);
      run_cycle("pre_stop_s0");
    end
    push_step(1, 1'b1);
    run_cycle("pre_stop_s1");
    stop = 1'b1;
    push_idle(1'b0, 1'b0);
    run_cycle("stop_in_s1");
    stop = 1'b0;
    push_idle(1'b0, 1'b0);
    run_cycle("stop_no_done");
    play_once();

    // start and stop together from IDLE
    start = 1'b1; stop = 1'b1;
    push_idle(1'b0, 1'b0);
    run_cycle("start_stop_0");
    start = 1'b0; stop = 1'b0;
    push_idle(1'b0, 1'b0);
    run_cycle("start_stop_1");
    push_idle(1'b0, 1'b0);
    run_cycle("start_stop_2");

    // Rewrite step 1 flags while step 1 is applied
    loop = 1'b1;
    do_start();
    for (int c = 0; c < 3; c++) begin
      push_step(0, c == 0);
      run_cycle("rw_s0");
    end
    push_step(1, 1'b1);
    run_cycle("rw_s1_old");
    wr_en = 1'b1; wr_addr = {SW'(1), 2'd0}; wr_data = 32'h0000_01DE;
    push_step(2, 1'b1);
    run_cycle("rw_s2");
    wr_en = 1'b0;
    m_flags[1] = 9'b111_011_110;
    for (int c = 0; c < 3; c++) begin
      push_step(0, c == 0);
      run_cycle("rw_s0_again");
    end
    push_step(1, 1'b1);
    run_cycle("rw_s1_new");
    stop = 1'b1;
    push_idle(1'b0, 1'b0);
    run_cycle("rw_stop");
    stop = 1'b0;
    loop = 1'b0;

    // Reset during RUN, then replay the preserved table
    do_start();
    push_step(0, 1'b1);
    run_cycle("pre_reset_s0");
    reset = 1'b1;
    m_dur = '0; m_step = '0;
    push_idle(1'b0, 1'b0);
    run_cycle("reset_in_run");
    reset = 1'b0;
    play_once();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
